// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with CY/ZERO/NEG/OVF flags, START/BUSY/DONE handshake
// Optional feature macro: ALU_MUL_EN (multi-cycle unsigned shift-add multiply on opcode 13)
module alu_seq #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [3:0]   ALUC,
  input  logic         START,
  output logic [W-1:0] OUT,
  output logic [W-1:0] OUT_HI,
  output logic         CY,
  output logic         ZERO,
  output logic         NEG,
  output logic         OVF,
  output logic         BUSY,
  output logic         DONE
);

  localparam logic [3:0] OP_PASS_A = 4'd0;
  localparam logic [3:0] OP_PASS_B = 4'd1;
  localparam logic [3:0] OP_NEG_A  = 4'd2;
  localparam logic [3:0] OP_NEG_B  = 4'd3;
  localparam logic [3:0] OP_ADD    = 4'd4;
  localparam logic [3:0] OP_ADC    = 4'd5;
  localparam logic [3:0] OP_OR     = 4'd6;
  localparam logic [3:0] OP_AND    = 4'd7;
  localparam logic [3:0] OP_ZERO   = 4'd8;
  localparam logic [3:0] OP_ONE    = 4'd9;
  localparam logic [3:0] OP_ONES   = 4'd10;
  localparam logic [3:0] OP_CLC    = 4'd11;
  localparam logic [3:0] OP_STC    = 4'd12;
  localparam logic [3:0] OP_MUL    = 4'd13;
  localparam logic [3:0] OP_SHL    = 4'd14;

  logic [W-1:0] out_q, out_d;
  logic         cy_q, cy_d;
  logic         zero_q, zero_d;
  logic         neg_q, neg_d;
  logic         ovf_q, ovf_d;
  logic         done_q, done_d;

  logic         busy;
  logic         accept;
  logic         cin;
  logic [W:0]   sum;
  logic [W-1:0] res;
  logic         wr_out;
  logic         ovf_new;

`ifdef ALU_MUL_EN
  localparam int CW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   out_hi_q, out_hi_d;
  logic [W-1:0]   mcand_q, mcand_d;
  logic [2*W-1:0] prod_q, prod_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W:0]     hi_sum;
  logic [2*W-1:0] prod_step;
  logic           mul_last;

  // MUL state register; an asynchronous reset drops any multiply in flight
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      out_hi_q <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      out_hi_q <= out_hi_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state: enter MUL on an accepted opcode 13, leave after the W-th iteration
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept && (ALUC == OP_MUL)) state_d = S_MUL;
      S_MUL:  if (mul_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // One shift-add iteration: low half holds the remaining multiplier bits
  always_comb begin
    hi_sum    = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
    prod_step = {hi_sum, prod_q[W-1:1]};
    mul_last  = busy && (cnt_q == CW'(W - 1));
  end

  // FSM outputs
  always_comb begin
    busy   = (state_q == S_MUL);
    OUT_HI = out_hi_q;
  end
`else
  // Without the multiplier there is never a multi-cycle op in flight
  always_comb begin
    busy   = 1'b0;
    OUT_HI = '0;
  end
`endif

  // Request is taken only while idle; START during a multiply is dropped
  always_comb accept = START && !busy;

  // Datapath next-state: decode accepted opcode and, when enabled, finish the multiply
  always_comb begin
    cin     = (ALUC == OP_ADC) ? cy_q : 1'b0;
    sum     = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, cin};
    res     = out_q;
    wr_out  = 1'b0;
    ovf_new = 1'b0;
    out_d   = out_q;
    cy_d    = cy_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
`ifdef ALU_MUL_EN
    out_hi_d = out_hi_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
`endif
    if (accept) begin
      done_d = 1'b1;
      case (ALUC)
        OP_PASS_A: begin res = A;      wr_out = 1'b1; end
        OP_PASS_B: begin res = B;      wr_out = 1'b1; end
        OP_NEG_A:  begin res = -A;     wr_out = 1'b1; end
        OP_NEG_B:  begin res = -B;     wr_out = 1'b1; end
        OP_ADD, OP_ADC: begin
          res     = sum[W-1:0];
          cy_d    = sum[W];
          ovf_new = (A[W-1] == B[W-1]) && (sum[W-1] != A[W-1]);
          wr_out  = 1'b1;
        end
        OP_OR:     begin res = A | B;  wr_out = 1'b1; end
        OP_AND:    begin res = A & B;  wr_out = 1'b1; end
        OP_ZERO:   begin res = '0;     wr_out = 1'b1; end
        OP_ONE:    begin res = {{(W-1){1'b0}}, 1'b1}; wr_out = 1'b1; end
        OP_ONES:   begin res = '1;     wr_out = 1'b1; end
        OP_CLC:    cy_d = 1'b0;
        OP_STC:    cy_d = 1'b1;
        OP_MUL: begin
`ifdef ALU_MUL_EN
          done_d  = 1'b0;
          mcand_d = A;
          prod_d  = {{W{1'b0}}, B};
          cnt_d   = '0;
`endif
        end
        OP_SHL: begin
          res    = {A[W-2:0], cy_q};
          cy_d   = A[W-1];
          wr_out = 1'b1;
        end
        default: ;
      endcase
      if (wr_out) begin
        out_d  = res;
        zero_d = (res == '0);
        neg_d  = res[W-1];
        ovf_d  = ovf_new;
`ifdef ALU_MUL_EN
        out_hi_d = '0;
`endif
      end
    end
`ifdef ALU_MUL_EN
    else if (busy) begin
      prod_d = prod_step;
      cnt_d  = cnt_q + CW'(1);
      if (mul_last) begin
        out_d    = prod_step[W-1:0];
        out_hi_d = prod_step[2*W-1:W];
        zero_d   = (prod_step == '0);
        neg_d    = prod_step[2*W-1];
        ovf_d    = 1'b0;
        done_d   = 1'b1;
      end
    end
`endif
  end

  // Result and flag registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_q  <= '0;
      cy_q   <= 1'b0;
      zero_q <= 1'b1;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      cy_q   <= cy_d;
      zero_q <= zero_d;
      neg_q  <= neg_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
    end
  end

  // Drive ports from the registers
  always_comb begin
    OUT  = out_q;
    CY   = cy_q;
    ZERO = zero_q;
    NEG  = neg_q;
    OVF  = ovf_q;
    BUSY = busy;
    DONE = done_q;
  end

endmodule
